// File: rtl/alu_seq.sv
// Registered ALU with a persistent NZVC condition-code register, carry chaining
// and a WIDTH-step shift-add unsigned multiplier behind a start/busy/done handshake.
module alu_seq #(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       ALU_Sel,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   output logic [WIDTH-1:0] ALU_Result,
   output logic [3:0]       NZVC,
   output logic             busy,
   output logic             done,
   output logic             err
);
   localparam int MSB = WIDTH - 1;
   localparam int CW  = $clog2(WIDTH);
   localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [3:0] OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBC = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7;
   localparam logic [3:0] OP_INC = 4'h8, OP_DEC = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB;
   localparam logic [3:0] OP_ASR = 4'hC, OP_MUL = 4'hD;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     res_q, res_d;
   logic [3:0]           nzvc_q, nzvc_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   logic                 cin, is_mul, legal, v_flag, c_flag;
   logic [WIDTH:0]       add_ext, sub_ext;
   logic [WIDTH-1:0]     alu_res;
   logic [3:0]           alu_nzvc, mul_nzvc;
   logic [2*WIDTH-1:0]   acc_step;
   logic                 mul_last;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         res_q    <= '0;
         nzvc_q   <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         res_q    <= res_d;
         nzvc_q   <= nzvc_d;
         done_q   <= done_d;
         err_q    <= err_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign is_mul   = (ALU_Sel == OP_MUL) && MUL_EN;
   assign mul_last = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start && is_mul) state_d = S_MUL;
         S_MUL:   if (mul_last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Carry-in only feeds the chained forms; plain ADD/SUB ignore the old C.
   assign cin     = ((ALU_Sel == OP_ADC) || (ALU_Sel == OP_SBC)) ? nzvc_q[0] : 1'b0;
   assign add_ext = {1'b0, In1} + {1'b0, In2} + (WIDTH+1)'(cin);
   assign sub_ext = {1'b0, In1} - {1'b0, In2} - (WIDTH+1)'(cin);

   always_comb begin
      alu_res = res_q;
      v_flag  = 1'b0;
      c_flag  = nzvc_q[0];
      legal   = 1'b1;
      case (ALU_Sel)
         OP_ADD, OP_ADC: begin
            alu_res = add_ext[WIDTH-1:0];
            c_flag  = add_ext[WIDTH];
            v_flag  = (In1[MSB] == In2[MSB]) && (alu_res[MSB] != In1[MSB]);
         end
         OP_SUB, OP_SBC: begin
            alu_res = sub_ext[WIDTH-1:0];
            c_flag  = sub_ext[WIDTH];
            v_flag  = (In1[MSB] != In2[MSB]) && (alu_res[MSB] != In1[MSB]);
         end
         OP_AND: alu_res = In1 & In2;
         OP_OR:  alu_res = In1 | In2;
         OP_XOR: alu_res = In1 ^ In2;
         OP_NOT: alu_res = ~In1;
         OP_INC: begin
            alu_res = In1 + WIDTH'(1);
            v_flag  = (In1 == MAX_POS);
         end
         OP_DEC: begin
            alu_res = In1 - WIDTH'(1);
            v_flag  = (In1 == MIN_NEG);
         end
         OP_SHL: begin
            alu_res = {In1[WIDTH-2:0], 1'b0};
            c_flag  = In1[MSB];
            v_flag  = alu_res[MSB] ^ In1[MSB];
         end
         OP_SHR: begin
            alu_res = {1'b0, In1[WIDTH-1:1]};
            c_flag  = In1[0];
         end
         OP_ASR: begin
            alu_res = {In1[MSB], In1[WIDTH-1:1]};
            c_flag  = In1[0];
         end
         default: legal = 1'b0;
      endcase
      alu_nzvc = {alu_res[MSB], (alu_res == '0), v_flag, c_flag};
   end

   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign mul_nzvc = {acc_step[MSB], (acc_step[WIDTH-1:0] == '0),
                      (acc_step[2*WIDTH-1:WIDTH] != '0), (acc_step[2*WIDTH-1:WIDTH] != '0)};

   always_comb begin
      res_d    = res_q;
      nzvc_d   = nzvc_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (is_mul) begin
                  mcand_d  = {{WIDTH{1'b0}}, In1};
                  mplier_d = In2;
                  acc_d    = '0;
                  cnt_d    = '0;
               end else if (legal) begin
                  res_d  = alu_res;
                  nzvc_d = alu_nzvc;
                  done_d = 1'b1;
               end else begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (mul_last) begin
               res_d  = acc_step[WIDTH-1:0];
               nzvc_d = mul_nzvc;
               done_d = 1'b1;
               cnt_d  = '0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      ALU_Result = res_q;
      NZVC       = nzvc_q;
      busy       = (state_q == S_MUL);
      done       = done_q;
      err        = err_q;
   end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: table-driven single-cycle ops checked through a scoreboard,
// plus hand-written MUL, reset-abort and MUL_EN=0 sequences.
module tb_alu_seq;
   logic       clock = 1'b0;
   logic       reset, start, start2;
   logic [3:0] sel, sel2;
   logic [7:0] a, b, a2, b2;
   logic [7:0] res, res2;
   logic [3:0] nzvc, nzvc2;
   logic       busy, done, err, busy2, done2, err2;

   always #5 clock = ~clock;

   alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
      .clock(clock), .reset(reset), .start(start), .ALU_Sel(sel), .In1(a), .In2(b),
      .ALU_Result(res), .NZVC(nzvc), .busy(busy), .done(done), .err(err));

   alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) dut_nomul (
      .clock(clock), .reset(reset), .start(start2), .ALU_Sel(sel2), .In1(a2), .In2(b2),
      .ALU_Result(res2), .NZVC(nzvc2), .busy(busy2), .done(done2), .err(err2));

   localparam logic [3:0] ADD = 4'h0, ADC = 4'h1, SUB = 4'h2, SBC = 4'h3, AND_ = 4'h4;
   localparam logic [3:0] OR_ = 4'h5, XOR_ = 4'h6, NOT_ = 4'h7, INC = 4'h8, DEC = 4'h9;
   localparam logic [3:0] SHL = 4'hA, SHR = 4'hB, ASR = 4'hC, MUL = 4'hD;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [3:0] nzvc;
      logic       err;
   } vec_t;

   typedef struct {
      logic [7:0] res;
      logic [3:0] nzvc;
      logic       err;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   n_txn  = 0;
   vec_t vecs[24];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 with res=0x%0h, expected no done (t=%0t)", res, $time);
         end else begin
            mon_e = sb_q.pop_front();
            n_txn++;
            $display("txn %0d: res=0x%02h nzvc=%04b err=%0b", n_txn, res, nzvc, err);
            check("sb_result", 16'(res), 16'(mon_e.res));
            check("sb_nzvc", 16'(nzvc), 16'(mon_e.nzvc));
            check("sb_err", 16'(err), 16'(mon_e.err));
         end
      end else if (err === 1'b1) begin
         check("err_without_done", 16'(err), 16'(0));
      end
   end

   task automatic launch(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
      @(negedge clock);
      sel   = op;
      a     = x;
      b     = y;
      start = 1'b1;
   endtask

   task automatic expect_txn(input logic [7:0] r, input logic [3:0] f, input logic e);
      exp_t t;
      t.res  = r;
      t.nzvc = f;
      t.err  = e;
      sb_q.push_back(t);
   endtask

   task automatic drain();
      int k = 0;
      while (sb_q.size() != 0 && k < 40) begin
         @(negedge clock);
         k++;
      end
      check("drain_empty", 16'(sb_q.size()), 16'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "timeout");
   end

   initial begin
      int done_seen;
      vecs[0]  = '{ADD,  8'h7F, 8'h01, 8'h80, 4'b1010, 1'b0};
      vecs[1]  = '{ADD,  8'hFF, 8'h01, 8'h00, 4'b0101, 1'b0};
      vecs[2]  = '{ADC,  8'h00, 8'h00, 8'h01, 4'b0000, 1'b0};
      vecs[3]  = '{SUB,  8'h05, 8'h07, 8'hFE, 4'b1001, 1'b0};
      vecs[4]  = '{SUB,  8'h80, 8'h01, 8'h7F, 4'b0010, 1'b0};
      vecs[5]  = '{SUB,  8'h00, 8'h01, 8'hFF, 4'b1001, 1'b0};
      vecs[6]  = '{AND_, 8'hF0, 8'h0F, 8'h00, 4'b0101, 1'b0};
      vecs[7]  = '{OR_,  8'h80, 8'h01, 8'h81, 4'b1001, 1'b0};
      vecs[8]  = '{XOR_, 8'hAA, 8'hAA, 8'h00, 4'b0101, 1'b0};
      vecs[9]  = '{NOT_, 8'h0F, 8'h33, 8'hF0, 4'b1001, 1'b0};
      vecs[10] = '{INC,  8'h7F, 8'h00, 8'h80, 4'b1011, 1'b0};
      vecs[11] = '{DEC,  8'h80, 8'h00, 8'h7F, 4'b0011, 1'b0};
      vecs[12] = '{SBC,  8'h10, 8'h05, 8'h0A, 4'b0000, 1'b0};
      vecs[13] = '{INC,  8'hFF, 8'h00, 8'h00, 4'b0100, 1'b0};
      vecs[14] = '{DEC,  8'h00, 8'h00, 8'hFF, 4'b1000, 1'b0};
      vecs[15] = '{SHL,  8'hC3, 8'h00, 8'h86, 4'b1001, 1'b0};
      vecs[16] = '{SHL,  8'h40, 8'h00, 8'h80, 4'b1010, 1'b0};
      vecs[17] = '{SHR,  8'h81, 8'h00, 8'h40, 4'b0001, 1'b0};
      vecs[18] = '{ASR,  8'h81, 8'h00, 8'hC0, 4'b1001, 1'b0};
      vecs[19] = '{ASR,  8'h01, 8'h00, 8'h00, 4'b0101, 1'b0};
      vecs[20] = '{ADD,  8'h80, 8'h80, 8'h00, 4'b0111, 1'b0};
      vecs[21] = '{4'hE, 8'h12, 8'h34, 8'h00, 4'b0111, 1'b1};
      vecs[22] = '{ADC,  8'h01, 8'h01, 8'h03, 4'b0000, 1'b0};
      vecs[23] = '{4'hF, 8'h56, 8'h78, 8'h03, 4'b0000, 1'b1};

      reset  = 1'b1;
      start  = 1'b0;
      sel    = 4'h0;
      a      = 8'h00;
      b      = 8'h00;
      start2 = 1'b0;
      sel2   = 4'h0;
      a2     = 8'h00;
      b2     = 8'h00;
      repeat (2) @(negedge clock);
      check("rst_result", 16'(res), 16'h00);
      check("rst_nzvc", 16'(nzvc), 16'h0);
      check("rst_busy", 16'(busy), 16'(0));
      check("rst_done", 16'(done), 16'(0));
      check("rst_err", 16'(err), 16'(0));
      reset = 1'b0;

      // Single ADD: one-cycle done pulse.
      launch(ADD, 8'h7F, 8'h01);
      expect_txn(8'h80, 4'b1010, 1'b0);
      @(negedge clock);
      start = 1'b0;
      check("add_done_hi", 16'(done), 16'(1));
      @(negedge clock);
      check("add_done_lo", 16'(done), 16'(0));

      // Back-to-back table vectors, one start per cycle.
      for (int i = 0; i < 24; i++) begin
         launch(vecs[i].op, vecs[i].a, vecs[i].b);
         expect_txn(vecs[i].res, vecs[i].nzvc, vecs[i].err);
      end
      @(negedge clock);
      start = 1'b0;
      drain();

      // MUL 0x10*0x10 with an ignored start mid-operation.
      launch(MUL, 8'h10, 8'h10);
      expect_txn(8'h00, 4'b0111, 1'b0);
      @(negedge clock);
      start = 1'b0;
      a     = 8'hFF;
      b     = 8'hFF;
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) @(negedge clock);
         check("mul_busy", 16'(busy), 16'(1));
         check("mul_no_done", 16'(done), 16'(0));
         if (k == 3) begin
            sel   = ADD;
            a     = 8'h01;
            b     = 8'h01;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clock);
      check("mul_busy_end", 16'(busy), 16'(0));
      check("mul_done", 16'(done), 16'(1));
      @(negedge clock);
      check("mul_done_lo", 16'(done), 16'(0));
      drain();

      launch(MUL, 8'h0F, 8'h03);
      expect_txn(8'h2D, 4'b0000, 1'b0);
      @(negedge clock);
      start = 1'b0;
      drain();

      // Illegal opcode holds result and flags.
      launch(4'hF, 8'h55, 8'hAA);
      expect_txn(8'h2D, 4'b0000, 1'b1);
      @(negedge clock);
      start = 1'b0;
      check("ill_err", 16'(err), 16'(1));
      check("ill_done", 16'(done), 16'(1));
      @(negedge clock);
      check("ill_err_lo", 16'(err), 16'(0));
      check("ill_done_lo", 16'(done), 16'(0));
      drain();

      // Reset in the third MUL cycle aborts with no done.
      launch(MUL, 8'hFF, 8'hFF);
      @(negedge clock);
      start = 1'b0;
      check("abort_busy", 16'(busy), 16'(1));
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("abort_busy_lo", 16'(busy), 16'(0));
      check("abort_result", 16'(res), 16'h00);
      check("abort_nzvc", 16'(nzvc), 16'h0);
      check("abort_done", 16'(done), 16'(0));
      reset = 1'b0;
      done_seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         if (done === 1'b1) done_seen++;
      end
      check("abort_no_done", 16'(done_seen), 16'(0));

      // Reset beats start on the same edge.
      @(negedge clock);
      reset = 1'b1;
      sel   = ADD;
      a     = 8'h01;
      b     = 8'h01;
      start = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      start = 1'b0;
      check("rst_vs_start_result", 16'(res), 16'h00);
      check("rst_vs_start_done", 16'(done), 16'(0));
      @(negedge clock);
      check("rst_vs_start_done2", 16'(done), 16'(0));

      // MUL_EN=0: opcode 1101 is illegal.
      @(negedge clock);
      sel2   = ADD;
      a2     = 8'h20;
      b2     = 8'h0D;
      start2 = 1'b1;
      @(negedge clock);
      check("nomul_add_result", 16'(res2), 16'h2D);
      check("nomul_add_nzvc", 16'(nzvc2), 16'h0);
      sel2   = MUL;
      a2     = 8'h03;
      b2     = 8'h05;
      @(negedge clock);
      start2 = 1'b0;
      check("nomul_err", 16'(err2), 16'(1));
      check("nomul_done", 16'(done2), 16'(1));
      check("nomul_busy", 16'(busy2), 16'(0));
      check("nomul_result", 16'(res2), 16'h2D);
      check("nomul_nzvc", 16'(nzvc2), 16'h0);
      @(negedge clock);
      check("nomul_err_lo", 16'(err2), 16'(0));
      check("nomul_done_lo", 16'(done2), 16'(0));

      check("final_queue_empty", 16'(sb_q.size()), 16'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
